// File: rtl/amba_pkg.sv
// Shared AMBA definitions for the memory slave and its masters: FSM state
// encoding, write-response codes, default error read data and the
// address-legality helper used when AMBA_SLAVE_ADDR_CHECK_EN is defined.
package amba_pkg;

   // Three bits leave spare encodings so a corrupted state is detectable.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_R_DATA = 3'd1,
      ST_W_ADDR = 3'd2,
      ST_W_RESP = 3'd3
   } state_e;

   localparam logic        BRESP_OKAY       = 1'b0;
   localparam logic        BRESP_SLVERR     = 1'b1;
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

   // A byte address is illegal when it is not word aligned or lies at or
   // beyond the end of a store holding 'depth' 32-bit words.
   function automatic logic addr_is_bad(input logic [31:0] addr,
                                        input int unsigned depth);
      logic [33:0] limit;
      limit = {2'b00, depth} << 2;
      return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
   endfunction

endpackage

// File: rtl/amba_slave_ram.sv
// Backing store for amba_memory_slave: DEPTH x 32 words, one synchronous
// write port and one synchronous read port with read enable. The read
// register holds its value between enabled reads.
module amba_slave_ram #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // Write on we_i, capture the addressed word on re_i.
   // NOTE: the array has no reset so it maps onto block RAM; only control state is reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/amba_memory_slave.sv
// AMBA-style single-outstanding memory slave. Reads return data one cycle
// after the address is accepted and hold it while RReady stays high; writes
// take the address, then data once BReady is high, then hold the response
// while BReady stays high. A simultaneous read and write gives the read
// priority; the write is accepted on the next return to idle.
// Optional feature: define AMBA_SLAVE_ADDR_CHECK_EN to flag misaligned or
// out-of-range addresses (reads return ERR_DATA, writes are dropped with
// SLVERR). Without it the word index wraps modulo DEPTH.
module amba_memory_slave
   import amba_pkg::*;
#(
   parameter int unsigned DEPTH    = 256,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
   input  logic        Aclk,
   input  logic        Aresetn,
   input  logic [31:0] ARAddr,
   input  logic        ARValid,
   output logic        ARReady,
   output logic [31:0] RData,
   output logic        RValid,
   input  logic        RReady,
   input  logic        RResp,
   input  logic [31:0] AWAddr,
   input  logic        AWValid,
   output logic        AWReady,
   input  logic [31:0] WData,
   input  logic        WValid,
   output logic        WReady,
   output logic        BResp,
   output logic        BValid,
   input  logic        BReady
);

   localparam int unsigned AW = $clog2(DEPTH);

   state_e        state_q, state_d;
   logic          arready_q, arready_d;
   logic          awready_q, awready_d;
   logic          wready_q, wready_d;
   logic          rvalid_q, rvalid_d;
   logic          bvalid_q, bvalid_d;
   logic          bresp_q, bresp_d;
   logic          rd_loaded_q, rd_loaded_d;
   logic          rd_err_q, rd_err_d;
   logic          wr_err_q, wr_err_d;
   logic [AW-1:0] widx_q, widx_d;
   logic          first_idle_q, first_idle_d;
   logic          ack_err_q, ack_err_d;

   logic          rd_accept;
   logic          wr_commit;
   logic [AW-1:0] ar_idx, aw_idx;
   logic          ar_bad, aw_bad;
   logic [31:0]   ram_rdata;
   logic          unused_addr_bits;

   assign ar_idx = ARAddr[AW+1:2];
   assign aw_idx = AWAddr[AW+1:2];

`ifdef AMBA_SLAVE_ADDR_CHECK_EN
   assign ar_bad = addr_is_bad(ARAddr, DEPTH);
   assign aw_bad = addr_is_bad(AWAddr, DEPTH);
`else
   assign ar_bad = 1'b0;
   assign aw_bad = 1'b0;
`endif

   // Bits outside the word index only matter to the optional address check.
   assign unused_addr_bits = ^{ARAddr[31:AW+2], ARAddr[1:0],
                               AWAddr[31:AW+2], AWAddr[1:0]};

   // Next-state and next-output decode for the transfer FSM.
   always_comb begin
      // NOTE: every _d gets its hold value first, so no branch can leave one unassigned and infer a latch.
      state_d      = state_q;
      arready_d    = arready_q;
      awready_d    = awready_q;
      wready_d     = wready_q;
      rvalid_d     = rvalid_q;
      bvalid_d     = bvalid_q;
      bresp_d      = bresp_q;
      rd_loaded_d  = rd_loaded_q;
      rd_err_d     = rd_err_q;
      wr_err_d     = wr_err_q;
      widx_d       = widx_q;
      rd_accept    = 1'b0;
      wr_commit    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ARValid && arready_q) begin
               rd_accept   = 1'b1;
               rd_loaded_d = 1'b1;
               rd_err_d    = ar_bad;
               rvalid_d    = 1'b1;
               arready_d   = 1'b0;
               awready_d   = 1'b0;
               state_d     = ST_R_DATA;
            end else if (AWValid && !ARValid && awready_q) begin
               widx_d    = aw_idx;
               wr_err_d  = aw_bad;
               arready_d = 1'b0;
               awready_d = 1'b0;
               wready_d  = 1'b1;
               state_d   = ST_W_ADDR;
            end else begin
               // Covers the first cycle after reset, when readies are still low.
               arready_d = 1'b1;
               awready_d = 1'b1;
            end
         end
         ST_R_DATA: begin
            if (!RReady) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               awready_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_W_ADDR: begin
            if (WValid && BReady) begin
               wr_commit = !wr_err_q;
               wready_d  = 1'b0;
               bvalid_d  = 1'b1;
               bresp_d   = wr_err_q ? BRESP_SLVERR : BRESP_OKAY;
               state_d   = ST_W_RESP;
            end
         end
         ST_W_RESP: begin
            if (!BReady) begin
               bvalid_d  = 1'b0;
               bresp_d   = BRESP_OKAY;
               arready_d = 1'b1;
               awready_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            arready_d = 1'b1;
            awready_d = 1'b1;
            wready_d  = 1'b0;
            rvalid_d  = 1'b0;
            bvalid_d  = 1'b0;
            bresp_d   = BRESP_OKAY;
         end
      endcase

      // The master's read-complete pulse is expected only in the first idle
      // cycle after a read; anywhere else it is remembered as an error.
      first_idle_d = (state_q == ST_R_DATA) && (state_d == ST_IDLE);
      ack_err_d    = ack_err_q | (RResp && !first_idle_q);
   end

   // Control and output registers, cleared immediately by Aresetn.
   always_ff @(posedge Aclk or negedge Aresetn) begin
      if (!Aresetn) begin
         state_q      <= ST_IDLE;
         arready_q    <= 1'b0;
         awready_q    <= 1'b0;
         wready_q     <= 1'b0;
         rvalid_q     <= 1'b0;
         bvalid_q     <= 1'b0;
         bresp_q      <= BRESP_OKAY;
         rd_loaded_q  <= 1'b0;
         rd_err_q     <= 1'b0;
         wr_err_q     <= 1'b0;
         widx_q       <= '0;
         first_idle_q <= 1'b0;
         ack_err_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         arready_q    <= arready_d;
         awready_q    <= awready_d;
         wready_q     <= wready_d;
         rvalid_q     <= rvalid_d;
         bvalid_q     <= bvalid_d;
         bresp_q      <= bresp_d;
         rd_loaded_q  <= rd_loaded_d;
         rd_err_q     <= rd_err_d;
         wr_err_q     <= wr_err_d;
         widx_q       <= widx_d;
         first_idle_q <= first_idle_d;
         ack_err_q    <= ack_err_d;
      end
   end

   amba_slave_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (Aclk),
      .we_i    (wr_commit),
      .waddr_i (widx_q),
      .wdata_i (WData),
      .re_i    (rd_accept),
      .raddr_i (ar_idx),
      .rdata_o (ram_rdata)
   );

   assign ARReady = arready_q;
   assign AWReady = awready_q;
   assign WReady  = wready_q;
   assign RValid  = rvalid_q;
   assign BValid  = bvalid_q;
   assign BResp   = bresp_q;
   // Selects only between registered sources; the RAM read register is not
   // reset, so RData reads zero until the first read after reset.
   assign RData   = rd_loaded_q ? (rd_err_q ? ERR_DATA : ram_rdata) : 32'h0;

endmodule

// File: doc/amba_memory_slave.md
AMBA_MEMORY_SLAVE -- requirements
Module: amba_memory_slave

Interface
REQ-001 Parameter DEPTH, 256, number of 32-bit words in the backing store (power of two, 16..4096).
REQ-002 Parameter ERR_DATA, 32'hDEADBEEF, RData value returned on an errored read.
REQ-003 Aclk  input  1  single clock; all state changes on the rising edge.
REQ-004 Aresetn  input  1  reset, asynchronous, active-low.
REQ-005 ARAddr  input  32  read byte address; word index = ARAddr[log2(DEPTH)+1:2].
REQ-006 ARValid  input  1  read address valid.
REQ-007 ARReady  output  1  slave can accept a read address.
REQ-008 RData  output  32  read data.
REQ-009 RValid  output  1  read data valid.
REQ-010 RReady  input  1  master waiting for read data.
REQ-011 RResp  input  1  master one-cycle read-complete acknowledge; ignored functionally, counted in the ack check (REQ-025).
REQ-012 AWAddr  input  32  write byte address; word index as REQ-005.
REQ-013 AWValid  input  1  write address valid.
REQ-014 AWReady  output  1  slave can accept a write address.
REQ-015 WData  input  32  write data.
REQ-016 WValid  input  1  write data valid.
REQ-017 WReady  output  1  slave can accept write data.
REQ-018 BResp  output  1  write response: 0 OKAY, 1 SLVERR.
REQ-019 BValid  output  1  write response valid.
REQ-020 BReady  input  1  master waiting for write response.

Function
REQ-021 States IDLE, R_DATA, W_ADDR, W_RESP; all outputs registered.
REQ-022 IDLE: ARReady=1, AWReady=1, WReady=0, RValid=0, BValid=0; the master starts a transfer only while the matching ready is high.
REQ-023 IDLE, ARValid=1 sampled: latch index, load RData from memory, RValid=1, ARReady=0, AWReady=0, go R_DATA (RValid high one cycle after ARValid seen).
REQ-024 R_DATA: hold RValid and RData stable while RReady=1; on RReady sampled 0, RValid=0, ARReady=1, AWReady=1, go IDLE.
REQ-025 RResp sampled 1 outside the first IDLE cycle after R_DATA sets sticky internal flag ack_err (visible only to the bench via hierarchy).
REQ-026 IDLE, AWValid=1 and ARValid=0: latch index, AWReady=0, ARReady=0, WReady=1, go W_ADDR.
REQ-027 ARValid and AWValid both 1 in IDLE: read wins; AWValid remains pending and is accepted on return to IDLE.
REQ-028 W_ADDR: on WValid=1 and BReady=1 sampled: write WData to latched index, WReady=0, BValid=1, BResp=0, go W_RESP; WValid without BReady waits.
REQ-029 W_RESP: hold BValid/BResp while BReady=1; on BReady sampled 0, BValid=0, ready outputs high, go IDLE.
REQ-030 Read of a word written in a preceding transaction returns the new value (no read-before-write hazard across transactions).
REQ-031 Illegal state encoding: next cycle IDLE with IDLE output values.

Reset
REQ-032 Aresetn=0 forces immediately: state IDLE, ARReady=0, AWReady=0, WReady=0, RValid=0, BValid=0, BResp=0, RData=0, ack_err=0.
REQ-033 Ready outputs rise on the first Aclk edge after Aresetn deasserts.
REQ-034 Reset mid-transaction aborts it; a write not yet past W_ADDR is not committed; memory contents are not reset.

Configuration
REQ-035 Macro AMBA_SLAVE_ADDR_CHECK_EN defined: byte address >= 4*DEPTH or address[1:0]!=0 is errored; errored read returns ERR_DATA, errored write is discarded with BResp=1.
REQ-036 Macro undefined: no checks; index taken modulo DEPTH, low two bits ignored, BResp always 0.

Structure
REQ-037 Shared package amba_pkg holds the state enum, BRESP_OKAY/BRESP_SLVERR constants and the default ERR_DATA; the master side imports the same package.
REQ-038 One sub-module amba_slave_ram: DEPTH x 32, synchronous write, synchronous read, no reset.

Verification
REQ-039 Reset release -> ARReady=1, AWReady=1 one edge later; RValid=0, BValid=0.
REQ-040 Write 0x12345678 to 0x10, then read 0x10 -> RValid=1 one cycle after ARValid, RData=0x12345678, BResp=0.
REQ-041 ARValid and AWValid same cycle (read 0x20, write 0x20 value 0xA5A5A5A5) -> read completes first with old data, then write; a second read returns 0xA5A5A5A5.
REQ-042 Aresetn pulsed low while in W_ADDR -> outputs at reset values immediately; a later read of that address returns its pre-write value.
REQ-043 With AMBA_SLAVE_ADDR_CHECK_EN, DEPTH=256: read 0x400 -> RData=0xDEADBEEF; write 0x402 -> BResp=1, memory unchanged; without macro, write 0x400 aliases word 0.
REQ-044 Master model holds RReady high for 5 cycles after RValid -> RValid and RData stable for all 5, ARReady=0 throughout, ack_err stays 0.
